mmu_stream_sequencer: RTL and testbench
=======================================

Name: mmu_stream_sequencer

Overview:
- Upstream driver for the 2x2 matrix multiply unit's memory-mapped port.
- Accepts four operand words on a valid/ready input stream and issues the four operand writes, then the control trigger write.
- Waits a fixed compute latency, then reads back the four result registers and emits them on a valid/ready output stream.
- Replaces hand-sequenced bus writes, so a producer can drive the accelerator without a CPU.

Parameters:
- WIDTH, 16: operand width; results are 2*WIDTH.
- BASE_ADDRESS, 32'h1000_0040: accelerator base; only bits [21:0] are used.
- CTRL_VALUE, 16'h00FF: data written to the control register (BASE+16) to start a computation.
- COMPUTE_CYCLES, 5: idle cycles between the trigger write and the first result read; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  sequencer can accept an operand.
- in_data  in  WIDTH  operand, in order A00, A01, B00, B10.
- mmu_wen  out  1  write enable to the matrix unit.
- mmu_addr  out  22  address to the matrix unit.
- mmu_wdata  out  WIDTH  write data to the matrix unit.
- mmu_rdata  in  2*WIDTH  read data from the matrix unit (combinational from mmu_addr).
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  2*WIDTH  result word, order Result0..Result3.
- busy  out  1  high from the first accepted operand until the last result handshake.
- done  out  1  one-cycle pulse in the cycle after the last result handshake.

Behaviour:
- Reset values: in_ready=0, mmu_wen=0, mmu_addr=0, mmu_wdata=0, out_valid=0, out_data=0, busy=0, done=0; FSM goes to LOAD with idx=0 and rcount=0.
- Reset mid-operation: partial operands and results are discarded; no bus write is issued in or after the reset cycle.
- Address: mmu_addr = BASE_ADDRESS[21:0] + offset, modulo 2^22. Offsets: 0, 4, 8, 12 for operands/results; 16 for control.
- All mmu_* and out_* outputs are registered.
- FSM states: LOAD, TRIG, WAIT, RADDR, EMIT.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) on beat k (0..3) produces, in the next cycle, mmu_wen=1, mmu_addr=base+4k, mmu_wdata=in_data.
  - busy rises in the cycle after the first handshake.
  - After the 4th handshake go to TRIG; in_ready=0 from then until the next LOAD.
  - Gaps in in_valid are allowed; mmu_wen=0 during gaps.
- TRIG:
  - Entered in the cycle that shows the beat-3 write.
  - Next cycle: mmu_wen=1, mmu_addr=base+16, mmu_wdata=CTRL_VALUE, for exactly one cycle.
  - Go to WAIT.
- WAIT:
  - mmu_wen=0; a counter runs COMPUTE_CYCLES cycles after the trigger cycle.
  - Go to RADDR.
- RADDR:
  - mmu_addr=base+4*rcount, held for one cycle.
  - Next edge: out_data<=mmu_rdata, out_valid<=1, go to EMIT.
- EMIT:
  - out_valid and out_data are held stable until out_ready.
  - On handshake: out_valid<=0 and rcount++.
  - If rcount was 3: done<=1 for one cycle, busy<=0, go to LOAD with idx=0. Otherwise go to RADDR.
- Throughput: at most one result per 2 cycles.
- out_ready asserted while out_valid=0 has no effect.
- in_valid outside LOAD is ignored and no beat is consumed.
- mmu_addr holds its last value whenever mmu_wen=0 outside RADDR/EMIT.
- rdata width mismatch is not possible: results are exactly 2*WIDTH and are neither truncated nor extended.

Optional Feature:
- Macro: MMU_STREAM_SEQUENCER_PERF_EN.
- With the macro: adds output perf_cycles, 32 bits, reset 0.
  - Cleared on the first LOAD handshake of a job.
  - Increments every cycle while busy.
  - Frozen at the done pulse, and readable until the next job starts.
  - Saturates at 32'hFFFF_FFFF.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic job:
  - Stimulus: operands 3, 2, 1, 4 streamed back-to-back; bench model's result regs return 3, 12, 2, 8; out_ready=1.
  - Response: writes to 22'h000040/44/48/4C with data 3/2/1/4 on consecutive cycles, then 22'h000050 with 16'h00FF; no mmu_wen for 5 cycles; out_data 3, 12, 2, 8 in order; one done pulse; busy low afterwards.
- Input gaps:
  - Stimulus: in_valid toggles 1,0,0,1,1,0,1.
  - Response: exactly 4 writes, each the cycle after its handshake, with correct addresses; no write in gap cycles.
- Output backpressure:
  - Stimulus: out_ready held 0 for 7 cycles on Result1.
  - Response: out_valid=1 and out_data=12 stable throughout; mmu_addr stays 22'h000044; no Result2 read until the handshake.
- Reset mid-job:
  - Stimulus: assert rst after the 2nd operand, then run the basic job.
  - Response: all outputs reset to 0; no trigger write from the aborted job; the new job's writes start at offset 0.
- Ignored input:
  - Stimulus: in_valid=1 with data 16'hDEAD during WAIT and EMIT.
  - Response: in_ready=0; no write to the matrix unit; the next job's first operand write carries its own data, not DEAD.
- With MMU_STREAM_SEQUENCER_PERF_EN:
  - Stimulus: basic job with out_ready=1.
  - Response: perf_cycles equals the cycles from the first handshake to the done pulse (bench-computed), and holds that value afterwards.

Source files
------------

// File: rtl/mmu_stream_sequencer.sv
// Streams four operands into the 2x2 matrix unit, triggers it, then reads back four results.
// Optional cycle counter output enabled by defining MMU_STREAM_SEQUENCER_PERF_EN.
module mmu_stream_sequencer #(
    parameter int                WIDTH          = 16,
    parameter logic [31:0]       BASE_ADDRESS   = 32'h1000_0040,
    parameter logic [WIDTH-1:0]  CTRL_VALUE     = WIDTH'(16'h00FF),
    parameter int                COMPUTE_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 mmu_wen,
    output logic [21:0]          mmu_addr,
    output logic [WIDTH-1:0]     mmu_wdata,
    input  logic [2*WIDTH-1:0]   mmu_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    output logic                 busy,
`ifdef MMU_STREAM_SEQUENCER_PERF_EN
    output logic                 done,
    output logic [31:0]          perf_cycles
`else
    output logic                 done
`endif
);

    typedef enum logic [2:0] {LOAD, TRIG, WAIT, RADDR, EMIT} state_t;

    localparam logic [21:0] BASE = BASE_ADDRESS[21:0];
    localparam int          CW   = $clog2(COMPUTE_CYCLES + 1);

    state_t        state;
    logic [1:0]    idx;
    logic [1:0]    rcount;
    logic [CW-1:0] wait_cnt;
    logic          in_hs;

    assign in_hs = in_valid && in_ready && (state == LOAD);

    // Slot 0..3 are operand/result registers, slot 4 is the control register.
    function automatic logic [21:0] slot_addr(input logic [2:0] slot);
        return BASE + {17'd0, slot, 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= 2'd0;
            rcount    <= 2'd0;
            wait_cnt  <= '0;
            in_ready  <= 1'b0;
            mmu_wen   <= 1'b0;
            mmu_addr  <= '0;
            mmu_wdata <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mmu_wen <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_hs) begin
                        mmu_wen   <= 1'b1;
                        mmu_addr  <= slot_addr({1'b0, idx});
                        mmu_wdata <= in_data;
                        busy      <= 1'b1;
                        idx       <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            in_ready <= 1'b0;
                            state    <= TRIG;
                        end
                    end
                end
                TRIG: begin
                    mmu_wen   <= 1'b1;
                    mmu_addr  <= slot_addr(3'd4);
                    mmu_wdata <= CTRL_VALUE;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == CW'(COMPUTE_CYCLES)) begin
                        mmu_addr <= slot_addr({1'b0, rcount});
                        state    <= RADDR;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RADDR: begin
                    out_data  <= mmu_rdata;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rcount    <= rcount + 2'd1;
                        if (rcount == 2'd3) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            idx      <= 2'd0;
                            in_ready <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            mmu_addr <= slot_addr({1'b0, rcount + 2'd1});
                            state    <= RADDR;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

`ifdef MMU_STREAM_SEQUENCER_PERF_EN
    // busy drops together with the done pulse, which freezes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (in_hs && idx == 2'd0) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mmu_stream_sequencer.sv
// Bench for mmu_stream_sequencer: timeline model of jobs checked every cycle,
// plus directed jobs with literal expectations.
module tb_mmu_stream_sequencer;

    localparam int          W  = 16;
    localparam int          CC = 5;
    localparam logic [21:0] B  = 22'h000040;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           mmu_wen;
    logic [21:0]    mmu_addr;
    logic [W-1:0]   mmu_wdata;
    logic [2*W-1:0] mmu_rdata;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_data;
    logic           busy;
    logic           done;
`ifdef MMU_STREAM_SEQUENCER_PERF_EN
    logic [31:0]    perf_cycles;
`endif

    mmu_stream_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mmu_wen(mmu_wen), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
        .mmu_rdata(mmu_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
`ifdef MMU_STREAM_SEQUENCER_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [21:0] A(input int off);
        return 22'(B + 22'(off));
    endfunction

    // Matrix unit result registers, filled from the operands of the job.
    logic [2*W-1:0] res [4] = '{default: '0};

    always_comb begin
        mmu_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 4; k++)
            if (mmu_addr == A(4 * k)) mmu_rdata = res[k];
    end

    // Expected outputs for the current cycle and job bookkeeping.
    logic           e_ir, e_wen, e_ov, e_busy, e_done;
    logic [21:0]    e_addr;
    logic [W-1:0]   e_wd;
    logic [2*W-1:0] e_od;
    logic [W-1:0]   op [4];
    int nb = 0, nr = 0, trig_at = -1, rd_at = -1;
    int cyc = 0;
    bit chk_en = 0;

    // Observations used by directed checks.
    logic [21:0]    wq_a[$];
    logic [W-1:0]   wq_d[$];
    logic [2*W-1:0] rq[$];
    int trig_c = -1, first_ov_c = -1, hs_c = -1, done_c = -1;

    task automatic model_step();
        logic nir, nwen, nov, nbusy, ndone;
        logic [21:0] nad;
        logic [W-1:0] nwd;
        logic [2*W-1:0] nod;
        if (rst) begin
            {e_ir, e_wen, e_ov, e_busy, e_done} = '0;
            e_addr = '0; e_wd = '0; e_od = '0;
            nb = 0; nr = 0; trig_at = -1; rd_at = -1;
            chk_en = 1;
            return;
        end
        nir = e_ir; nwen = 0; nad = e_addr; nwd = e_wd;
        nov = e_ov; nod = e_od; nbusy = e_busy; ndone = 0;
        if (nb < 4) begin
            if (e_ir && in_valid) begin
                nwen = 1; nad = A(4 * nb); nwd = in_data; nbusy = 1;
                op[nb] = in_data;
                nb++;
                if (nb == 4) begin
                    nir = 0;
                    trig_at = cyc + 2;
                    res[0] = 32'(op[0]) * 32'(op[2]);
                    res[1] = 32'(op[0]) * 32'(op[3]);
                    res[2] = 32'(op[1]) * 32'(op[2]);
                    res[3] = 32'(op[1]) * 32'(op[3]);
                end
            end else begin
                nir = 1;
            end
        end
        if (cyc + 1 == trig_at) begin
            nwen = 1; nad = A(16); nwd = 16'h00FF;
            rd_at = cyc + CC + 2;
        end
        if (e_ov && out_ready) begin
            nov = 0;
            nr++;
            if (nr == 4) begin
                ndone = 1; nbusy = 0; nb = 0; nr = 0; nir = 1;
            end else begin
                rd_at = cyc + 1;
            end
        end
        if (cyc + 1 == rd_at) nad = A(4 * nr);
        if (cyc == rd_at) begin
            nov = 1; nod = res[nr];
        end
        e_ir = nir; e_wen = nwen; e_addr = nad; e_wd = nwd;
        e_ov = nov; e_od = nod; e_busy = nbusy; e_done = ndone;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en)
                chk($sformatf("cycle%0d", cyc),
                    {in_ready, mmu_wen, mmu_addr, mmu_wdata,
                     out_valid, out_data, busy, done},
                    {e_ir, e_wen, e_addr, e_wd, e_ov, e_od, e_busy, e_done});
            if (mmu_wen) begin
                wq_a.push_back(mmu_addr);
                wq_d.push_back(mmu_wdata);
                if (mmu_addr == A(16)) trig_c = cyc;
            end
            if (out_valid && first_ov_c < 0) first_ov_c = cyc;
            if (out_valid && out_ready) rq.push_back(out_data);
            if (in_valid && in_ready && hs_c < 0) hs_c = cyc;
            if (done) done_c = cyc;
            model_step();
            cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        wq_a.delete(); wq_d.delete(); rq.delete();
        trig_c = -1; first_ov_c = -1; hs_c = -1; done_c = -1;
    endtask

    task automatic send_ops(input logic [W-1:0] a, b, c, d,
                            input logic [6:0] vpat, input bit rnd,
                            input int stop);
        logic [W-1:0] v [4];
        int k = 0, t = 0, budget = 200;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        while (k < stop && budget > 0) begin
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : vpat[6 - (t % 7)];
            in_data   = in_valid ? v[k] : W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) k++;
            t++;
            budget--;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (k < stop) chk("operand accept timeout", 128'(k), 128'(stop));
    endtask

    task automatic wait_done(input int mode, input bit dead);
        int stall = 0, seen = 0, budget = 400;
        bit got = 0;
        while (!got && budget > 0) begin
            in_valid = dead && seen < 4;
            in_data  = in_valid ? 16'hDEAD : 16'h0;
            if (mode == 0) out_ready = 1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = !(seen == 1 && stall < 7);
            @(negedge clk);
            if (dead && in_valid) chk("ignored in_ready", 128'(in_ready), 128'(0));
            if (mode == 2 && seen == 1 && out_valid && !out_ready) begin
                stall++;
                if (stall == 7) begin
                    chk("backpressure data", 128'(out_data), 128'(12));
                    chk("backpressure addr", 128'(mmu_addr), 128'(22'h000044));
                end
            end
            if (out_valid && out_ready) seen++;
            if (done) got = 1;
            budget--;
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!got) chk("done timeout", 128'(0), 128'(1));
    endtask

    task automatic chk_basic_writes(input string nm);
        logic [21:0]  ea [5];
        logic [W-1:0] ed [5];
        ea = '{22'h40, 22'h44, 22'h48, 22'h4C, 22'h50};
        ed = '{16'd3, 16'd2, 16'd1, 16'd4, 16'h00FF};
        chk({nm, " nwrites"}, 128'(wq_a.size()), 128'(5));
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s write%0d", nm, i),
                i < wq_a.size() ? {wq_a[i], wq_d[i]} : 'x,
                {ea[i], ed[i]});
    endtask

    initial begin
        logic [2*W-1:0] er [4];
        logic [W-1:0]   g [4];
        er = '{32'd3, 32'd12, 32'd2, 32'd8};
        in_valid = 0; in_data = 0; out_ready = 0; rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset state", {in_ready, mmu_wen, mmu_addr, mmu_wdata,
                            out_valid, out_data, busy, done}, '0);
        @(posedge clk); #1;

        // Basic job
        clear_obs();
        send_ops(16'd3, 16'd2, 16'd1, 16'd4, 7'h7F, 0, 4);
        wait_done(0, 0);
        chk_basic_writes("basic");
        chk("basic nresults", 128'(rq.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("basic result%0d", i),
                i < rq.size() ? rq[i] : 'x, er[i]);
        chk("trigger to first result", 128'(first_ov_c - trig_c), 128'(7));
`ifdef MMU_STREAM_SEQUENCER_PERF_EN
        chk("perf at done", 128'(perf_cycles), 128'(done_c - hs_c - 1));
        repeat (3) @(posedge clk);
        #1;
        chk("perf held", 128'(perf_cycles), 128'(done_c - hs_c - 1));
`endif
        @(negedge clk);
        chk("done single pulse", 128'(done), 128'(0));
        chk("busy after job", 128'(busy), 128'(0));
        @(posedge clk); #1;

        // Input gaps
        clear_obs();
        send_ops(16'h0011, 16'h0022, 16'h0033, 16'h0044, 7'b1001101, 0, 4);
        wait_done(1, 0);
        chk("gap write0", {wq_a[0], wq_d[0]}, {22'h40, 16'h0011});
        chk("gap write3", {wq_a[3], wq_d[3]}, {22'h4C, 16'h0044});

        // Output backpressure
        clear_obs();
        send_ops(16'd3, 16'd2, 16'd1, 16'd4, 7'h7F, 0, 4);
        wait_done(2, 0);
        chk("backpressure result1", rq[1], 128'(12));

        // Reset mid-job
        send_ops(16'h0101, 16'h0202, 16'h0303, 16'h0404, 7'h7F, 0, 2);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mid-job reset state", {in_ready, mmu_wen, mmu_addr, mmu_wdata,
                                    out_valid, out_data, busy, done}, '0);
        @(posedge clk); #1;
        clear_obs();
        send_ops(16'd3, 16'd2, 16'd1, 16'd4, 7'h7F, 0, 4);
        wait_done(0, 0);
        chk_basic_writes("after reset");

        // Ignored input during WAIT/EMIT
        clear_obs();
        send_ops(16'd3, 16'd2, 16'd1, 16'd4, 7'h7F, 0, 4);
        wait_done(0, 1);
        chk_basic_writes("dead");
        clear_obs();
        send_ops(16'h1234, 16'h0005, 16'h0006, 16'h0007, 7'h7F, 0, 4);
        wait_done(0, 0);
        chk("next job first write", {wq_a[0], wq_d[0]}, {22'h40, 16'h1234});

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < 4; i++) g[i] = W'($urandom);
            clear_obs();
            send_ops(g[0], g[1], g[2], g[3], 7'($urandom_range(1, 127)),
                     1'($urandom_range(0, 1)), 4);
            wait_done(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
